// File: rtl/keypad_code_entry_pkg.sv
// Shared definitions for the keypad code-entry front end: state encoding,
// key codes, code limit and datapath widths.
package keypad_code_entry_pkg;

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned ACC_W   = 8;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned FAIL_W  = 3;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = 3'd0,
        ST_COLLECT     = 3'd1,
        ST_SUBMIT      = 3'd2,
        ST_WAIT_RESULT = 3'd3,
        ST_LOCKOUT     = 3'd4
    } state_e;

    localparam logic [KEY_W-1:0] KEY_CLEAR = 4'hA;
    localparam logic [KEY_W-1:0] KEY_ENTER = 4'hB;
    localparam logic [ACC_W-1:0] MAX_CODE  = 8'd15;

    // Key codes 0..9 are digits; everything above is a command or ignored.
    function automatic logic is_digit(input logic [KEY_W-1:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_code_entry_timer.sv
// Shared phase timer: up-counter with synchronous clear and a terminal-count
// compare against a limit chosen by the owner each cycle.
// Ports:
//   clk, reset_n   clock / synchronous active-low reset
//   clear_i        force the count to zero next cycle (wins over en_i)
//   en_i           advance the count by one
//   limit_i        terminal value for the current phase
//   tc_c_o         combinational: count currently equals limit_i
module keypad_code_entry_timer #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             tc_c_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_c_o = (count_q == limit_i);

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad code entry: collects up to two decimal digits, submits the resulting
// 4-bit code with a validate pulse, watches door-open feedback for the result
// and locks the keypad after repeated failed attempts.
// Ports:
//   clk, reset_n      clock / synchronous active-low reset
//   key_valid         one-cycle strobe qualifying key_value
//   key_value         0-9 digit, A clear, B enter, C-F ignored
//   open_access_door  grant feedback from the downstream access FSM
//   validate_code     one-cycle submit pulse (high during SUBMIT)
//   access_code       submitted code, held until the return to IDLE
//   entry_error       one-cycle pulse after a malformed or timed-out entry
//   locked_out        high for the whole lockout period
//   state_out         current state encoding
module keypad_code_entry
    import keypad_code_entry_pkg::*;
#(
    parameter int unsigned DIGIT_TIMEOUT  = 32,
    parameter int unsigned RESULT_WINDOW  = 4,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               key_valid,
    input  logic [KEY_W-1:0]   key_value,
    input  logic               open_access_door,
    output logic               validate_code,
    output logic [KEY_W-1:0]   access_code,
    output logic               entry_error,
    output logic               locked_out,
    output logic [STATE_W-1:0] state_out
);

    // One timer serves all three phases, so it is sized for the longest one.
    localparam int unsigned TMR_MAX_A = (DIGIT_TIMEOUT > RESULT_WINDOW) ? DIGIT_TIMEOUT : RESULT_WINDOW;
    localparam int unsigned TMR_MAX   = (TMR_MAX_A > LOCKOUT_CYCLES) ? TMR_MAX_A : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W     = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FAIL_W-1:0]   fails_q, fails_d;
    logic [KEY_W-1:0]    code_q, code_d;
    logic                validate_q;
    logic                err_q;
    logic                locked_q;

    logic                err_c;
    logic                tmr_clr_c;
    logic                tmr_en_c;
    logic [TMR_W-1:0]    tmr_limit_c;
    logic                tmr_tc_c;
    logic [ACC_W-1:0]    acc_next_c;
    logic [FAIL_W-1:0]   fails_inc_c;

    // acc*10 + d never exceeds 99 here (acc <= 9 when a second digit arrives).
    assign acc_next_c  = acc_q * ACC_W'(10) + ACC_W'(key_value);
    assign fails_inc_c = fails_q + FAIL_W'(1);

    keypad_code_entry_timer #(
        .WIDTH (TMR_W)
    ) u_entry_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (tmr_clr_c),
        .en_i    (tmr_en_c),
        .limit_i (tmr_limit_c),
        .tc_c_o  (tmr_tc_c)
    );

    // Next-state, datapath and timer control.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        fails_d     = fails_q;
        code_d      = code_q;
        err_c       = 1'b0;
        tmr_clr_c   = 1'b0;
        tmr_en_c    = 1'b0;
        tmr_limit_c = '0;

        unique case (state_q)
            ST_IDLE: begin
                tmr_clr_c = 1'b1;
                if (key_valid && is_digit(key_value)) begin
                    acc_d   = ACC_W'(key_value);
                    cnt_d   = CNT_W'(1);
                    state_d = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                tmr_limit_c = TMR_W'(DIGIT_TIMEOUT - 1);
                if (key_valid) begin
                    // Any key, even an ignored code, restarts the inter-key timeout.
                    tmr_clr_c = 1'b1;
                    if (is_digit(key_value)) begin
                        if ((cnt_q == CNT_W'(1)) && (acc_next_c <= MAX_CODE)) begin
                            acc_d = acc_next_c;
                            cnt_d = CNT_W'(2);
                        end else begin
                            err_c   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (key_value == KEY_CLEAR) begin
                        state_d = ST_IDLE;
                    end else if (key_value == KEY_ENTER) begin
                        code_d  = acc_q[KEY_W-1:0];
                        state_d = ST_SUBMIT;
                    end
                end else if (tmr_tc_c) begin
                    tmr_clr_c = 1'b1;
                    err_c     = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmr_en_c = 1'b1;
                end
            end

            ST_SUBMIT: begin
                tmr_clr_c = 1'b1;
                state_d   = ST_WAIT_RESULT;
            end

            ST_WAIT_RESULT: begin
                tmr_limit_c = TMR_W'(RESULT_WINDOW - 1);
                // Grant is checked first so it wins over a coincident expiry.
                if (open_access_door) begin
                    tmr_clr_c = 1'b1;
                    fails_d   = '0;
                    state_d   = ST_IDLE;
                end else if (tmr_tc_c) begin
                    tmr_clr_c = 1'b1;
                    fails_d   = fails_inc_c;
                    if (fails_inc_c == FAIL_W'(MAX_FAILS)) begin
                        state_d = ST_LOCKOUT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tmr_en_c = 1'b1;
                end
            end

            ST_LOCKOUT: begin
                tmr_limit_c = TMR_W'(LOCKOUT_CYCLES - 1);
                if (tmr_tc_c) begin
                    tmr_clr_c = 1'b1;
                    fails_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    tmr_en_c = 1'b1;
                end
            end

            default: begin
                tmr_clr_c = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase

        // Every path into IDLE drops the entry and the presented code.
        if (state_d == ST_IDLE) begin
            acc_d  = '0;
            cnt_d  = '0;
            code_d = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            fails_q    <= '0;
            code_q     <= '0;
            validate_q <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            fails_q    <= fails_d;
            code_q     <= code_d;
            validate_q <= (state_d == ST_SUBMIT);
            err_q      <= err_c;
            locked_q   <= (state_d == ST_LOCKOUT);
        end
    end

    assign validate_code = validate_q;
    assign access_code   = code_q;
    assign entry_error   = err_q;
    assign locked_out    = locked_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Bench for keypad_code_entry: directed scenarios with literal expectations,
// then randomized keys/door feedback checked every cycle against a
// behavioural model of the entry rules.
module tb_keypad_code_entry;

    localparam int DT = 32;
    localparam int RW = 4;
    localparam int MF = 3;
    localparam int LC = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_value = 4'd0;
    logic       open_access_door = 1'b0;
    logic       validate_code;
    logic [3:0] access_code;
    logic       entry_error;
    logic       locked_out;
    logic [2:0] state_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    keypad_code_entry #(
        .DIGIT_TIMEOUT  (DT),
        .RESULT_WINDOW  (RW),
        .MAX_FAILS      (MF),
        .LOCKOUT_CYCLES (LC)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .key_valid        (key_valid),
        .key_value        (key_value),
        .open_access_door (open_access_door),
        .validate_code    (validate_code),
        .access_code      (access_code),
        .entry_error      (entry_error),
        .locked_out       (locked_out),
        .state_out        (state_out)
    );

    // Behavioural model: phase number, digits typed so far, elapsed counts.
    int m_state = 0;
    int m_code = 0;
    int m_fails = 0;
    int m_idle = 0;
    int m_elapsed = 0;
    int m_lock_left = 0;
    bit m_err = 1'b0;
    int digits[$];

    // Door responder and stimulus controls.
    int since_v = -1;
    int door_lat = 0;
    int door_fixed = 0;
    bit noise_en = 1'b0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    function automatic int digits_value();
        int v = 0;
        foreach (digits[i]) v = v * 10 + digits[i];
        return v;
    endfunction

    task automatic go_idle();
        m_state = 0;
        m_code = 0;
        m_idle = 0;
        digits.delete();
    endtask

    // One clock of the entry rules, applied to the inputs of that cycle.
    task automatic model_step();
        int k;
        k = int'(key_value);
        m_err = 1'b0;
        if (!reset_n) begin
            go_idle();
            m_fails = 0;
            m_elapsed = 0;
            m_lock_left = 0;
            return;
        end
        case (m_state)
            0: if (key_valid && k <= 9) begin
                digits.delete();
                digits.push_back(k);
                m_idle = 0;
                m_state = 1;
            end
            1: if (key_valid) begin
                m_idle = 0;
                if (k <= 9) begin
                    if (digits.size() == 1 && digits[0] * 10 + k <= 15) digits.push_back(k);
                    else begin m_err = 1'b1; go_idle(); end
                end else if (k == 10) begin
                    go_idle();
                end else if (k == 11) begin
                    m_code = digits_value();
                    m_state = 2;
                end
            end else begin
                m_idle++;
                if (m_idle >= DT) begin m_err = 1'b1; go_idle(); end
            end
            2: begin m_state = 3; m_elapsed = 0; end
            3: begin
                m_elapsed++;
                if (open_access_door) begin
                    m_fails = 0;
                    go_idle();
                end else if (m_elapsed >= RW) begin
                    m_fails++;
                    if (m_fails >= MF) begin m_state = 4; m_lock_left = LC; end
                    else go_idle();
                end
            end
            4: begin
                m_lock_left--;
                if (m_lock_left == 0) begin m_fails = 0; go_idle(); end
            end
            default: go_idle();
        endcase
    endtask

    // Apply one cycle of key input, advance the model, then prepare door feedback.
    task automatic tick(input bit kv, input logic [3:0] kval);
        key_valid = kv;
        key_value = kval;
        @(posedge clk);
        model_step();
        #1;
        key_valid = 1'b0;
        if (m_state == 2) begin
            since_v = 0;
            door_lat = (door_fixed >= 0) ? door_fixed : int'($urandom_range(0, 6));
        end else if (since_v >= 0) begin
            since_v = (since_v > 100) ? -1 : since_v + 1;
        end
        open_access_door = ((door_lat > 0) && (since_v == door_lat)) ||
                           (noise_en && ($urandom_range(0, 15) == 0));
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", 32'(state_out), 32'(m_state));
            chk("validate", 32'(validate_code), 32'(m_state == 2));
            chk("code", 32'(access_code), 32'((m_state >= 2) ? m_code : 0));
            chk("error", 32'(entry_error), 32'(m_err));
            chk("locked", 32'(locked_out), 32'(m_state == 4));
        end
    end

    initial begin
        int n;
        int r;
        logic [3:0] kk;

        reset_n = 1'b0;
        tick(0, 4'd0);
        tick(0, 4'd0);
        cmp_en = 1'b1;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_outs", 32'({validate_code, entry_error, locked_out, access_code}), 32'd0);
        reset_n = 1'b1;
        tick(0, 4'd0);

        // 0,9,ENTER with grant two cycles after validate
        door_fixed = 2;
        tick(1, 4'd0);
        tick(1, 4'd9);
        tick(1, 4'hB);
        chk("t1_validate", 32'(validate_code), 32'd1);
        chk("t1_code", 32'(access_code), 32'd9);
        tick(0, 4'd0);
        chk("t1_pulse_len", 32'(validate_code), 32'd0);
        chk("t1_code_held", 32'(access_code), 32'd9);
        tick(0, 4'd0);
        tick(0, 4'd0);
        chk("t1_idle", 32'(state_out), 32'd0);
        chk("t1_code_clr", 32'(access_code), 32'd0);

        // 1,6 exceeds the code limit
        tick(1, 4'd1);
        tick(1, 4'd6);
        chk("t2_error", 32'(entry_error), 32'd1);
        chk("t2_idle", 32'(state_out), 32'd0);
        tick(0, 4'd0);
        chk("t2_err_pulse", 32'(entry_error), 32'd0);

        // 1,2,3 too many digits; then 7,CLEAR silently
        tick(1, 4'd1);
        tick(1, 4'd2);
        chk("t3_collect", 32'(state_out), 32'd1);
        tick(1, 4'd3);
        chk("t3_error", 32'(entry_error), 32'd1);
        tick(1, 4'd7);
        tick(1, 4'hA);
        chk("t3_clear_idle", 32'(state_out), 32'd0);
        chk("t3_clear_noerr", 32'(entry_error), 32'd0);

        // 5 then silence until the digit timeout
        tick(1, 4'd5);
        for (int i = 0; i < DT - 1; i++) tick(0, 4'd0);
        chk("t4_still_collect", 32'(state_out), 32'd1);
        tick(0, 4'd0);
        chk("t4_timeout_err", 32'(entry_error), 32'd1);
        chk("t4_idle", 32'(state_out), 32'd0);

        // Three failed submissions of code 2 lead to lockout
        door_fixed = 0;
        for (int a = 0; a < 3; a++) begin
            tick(1, 4'd2);
            tick(1, 4'hB);
            for (int i = 0; i < 5; i++) tick(0, 4'd0);
        end
        chk("t5_locked", 32'(locked_out), 32'd1);
        chk("t5_state", 32'(state_out), 32'd4);
        chk("t5_code_held", 32'(access_code), 32'd2);
        n = 0;
        while (locked_out === 1'b1 && n < 200) begin
            n++;
            kk = 4'($urandom_range(0, 15));
            tick(1, kk);
        end
        chk("t5_lock_len", 32'(n), 32'd64);
        chk("t5_after_idle", 32'(state_out), 32'd0);
        door_fixed = 2;
        tick(1, 4'd1);
        tick(1, 4'd5);
        tick(1, 4'hB);
        chk("t5_good_validate", 32'(validate_code), 32'd1);
        chk("t5_good_code", 32'(access_code), 32'd15);
        for (int i = 0; i < 3; i++) tick(0, 4'd0);
        chk("t5_granted_idle", 32'(state_out), 32'd0);

        // Reset during WAIT_RESULT
        door_fixed = 0;
        tick(1, 4'd8);
        tick(1, 4'hB);
        tick(0, 4'd0);
        chk("t6_wait", 32'(state_out), 32'd3);
        reset_n = 1'b0;
        tick(0, 4'd0);
        chk("t6_rst_state", 32'(state_out), 32'd0);
        chk("t6_rst_outs", 32'({validate_code, entry_error, locked_out, access_code}), 32'd0);
        reset_n = 1'b1;
        tick(0, 4'd0);

        // Randomized traffic
        door_fixed = -1;
        noise_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            r = int'($urandom_range(0, 999));
            reset_n = (r != 0);
            if (r < 5) begin
                for (int i = 0; i < 40; i++) tick(0, 4'd0);
            end else if (r < 450) begin
                tick(0, 4'd0);
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 35)      kk = 4'($urandom_range(0, 1));
                else if (r < 60) kk = 4'($urandom_range(0, 9));
                else if (r < 82) kk = 4'hB;
                else if (r < 90) kk = 4'hA;
                else             kk = 4'($urandom_range(12, 15));
                tick(1, kk);
            end
        end
        reset_n = 1'b1;
        tick(0, 4'd0);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
